// File: rtl/rate_tick_counter_if.sv
// ----------------------------------------------------------------------------
// rate_tick_counter_if
//   Groups the control and status signals of rate_tick_counter into a single
//   bundle. The clock and reset stay outside as plain ports of the counter.
//
//   Macro: RTC_LOAD_EN adds the synchronous load strobe and load value.
//
//   Signals
//     enable      master -> slave   1 = divider and counter run, 0 = hold
//     rate_sel    master -> slave   divisor select (00 = every cycle)
//     up_dn       master -> slave   1 = count up, 0 = count down
//     load        master -> slave   [RTC_LOAD_EN] synchronous load strobe
//     load_value  master -> slave   [RTC_LOAD_EN] value to load (clamped)
//     tick        slave  -> master  one-cycle pulse at the selected rate
//     count       slave  -> master  current count
//     wrap        slave  -> master  one-cycle pulse when count wraps
// ----------------------------------------------------------------------------
interface rate_tick_counter_if #(
    parameter int CNT_W = 4
);
    logic             enable;
    logic [1:0]       rate_sel;
    logic             up_dn;
    logic             tick;
    logic [CNT_W-1:0] count;
    logic             wrap;
`ifdef RTC_LOAD_EN
    logic             load;
    logic [CNT_W-1:0] load_value;

    modport master (output enable, rate_sel, up_dn, load, load_value,
                    input  tick, count, wrap);
    modport slave  (input  enable, rate_sel, up_dn, load, load_value,
                    output tick, count, wrap);
`else
    modport master (output enable, rate_sel, up_dn,
                    input  tick, count, wrap);
    modport slave  (input  enable, rate_sel, up_dn,
                    output tick, count, wrap);
`endif
endinterface

// File: rtl/rate_tick_counter.sv
// ----------------------------------------------------------------------------
// rate_tick_counter
//   Programmable tick divider driving a modulo up/down counter. The tick is a
//   clock enable inside the single clock domain, never a derived clock.
//
//   Macro: RTC_LOAD_EN adds a synchronous load of the counter (clamped to
//   MODULUS-1) that takes priority over tick and ignores enable.
//
//   Ports
//     clock   in    system clock
//     reset   in    asynchronous, active-high reset
//     bus     slave rate_tick_counter_if (enable, rate_sel, up_dn, tick,
//                   count, wrap, and load/load_value with RTC_LOAD_EN)
//
//   Parameters
//     DIV_W    divider width, every DIVn must be below 2**DIV_W
//     DIV1..3  divisors for rate_sel 01/10/11 (tick period is DIVn+1)
//     CNT_W    counter width
//     MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**CNT_W
// ----------------------------------------------------------------------------
module rate_tick_counter #(
    parameter int DIV_W   = 28,
    parameter int DIV1    = 49999999,
    parameter int DIV2    = 99999999,
    parameter int DIV3    = 199999999,
    parameter int CNT_W   = 4,
    parameter int MODULUS = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    rate_tick_counter_if.slave    bus
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MODULUS - 1);

    logic [DIV_W-1:0] r_divQ;
    logic [1:0]       r_selQ;
    logic [CNT_W-1:0] r_count;
    logic             r_wrap;

    logic [DIV_W-1:0] w_divReload;
    logic             w_selChange;
    logic             w_tick;
    logic [CNT_W-1:0] w_countNext;
    logic             w_atTerminal;

    // Reload value for the currently requested rate; DIV0 is zero so that
    // rate_sel=00 ticks on every enabled cycle.
    always_comb begin
        w_divReload = '0;
        case (bus.rate_sel)
            2'b01:   w_divReload = DIV_W'(DIV1);
            2'b10:   w_divReload = DIV_W'(DIV2);
            2'b11:   w_divReload = DIV_W'(DIV3);
            default: w_divReload = '0;
        endcase
    end

    // A rate change restarts the divider and suppresses the tick for that
    // cycle. Reset also masks the tick because the cleared divider would
    // otherwise look like an expired count while reset is still held.
    assign w_selChange = (bus.rate_sel != r_selQ);
    assign w_tick      = !reset && bus.enable && (r_divQ == '0) && !w_selChange;

    // Divider state: the restart on a rate change happens even while
    // disabled, so the new period is always measured from the change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_divQ <= '0;
            r_selQ <= 2'b00;
        end else if (w_selChange) begin
            r_divQ <= w_divReload;
            r_selQ <= bus.rate_sel;
        end else if (bus.enable) begin
            if (r_divQ == '0) begin
                r_divQ <= w_divReload;
            end else begin
                r_divQ <= r_divQ - DIV_W'(1);
            end
        end
    end

    // Next count and terminal detection for the sampled direction. Explicit
    // compares against the terminal values keep non-power-of-2 moduli exact.
    always_comb begin
        w_countNext  = r_count;
        w_atTerminal = 1'b0;
        if (bus.up_dn) begin
            w_atTerminal = (r_count == CntMax);
            w_countNext  = w_atTerminal ? '0 : r_count + CNT_W'(1);
        end else begin
            w_atTerminal = (r_count == '0);
            w_countNext  = w_atTerminal ? CntMax : r_count - CNT_W'(1);
        end
    end

`ifdef RTC_LOAD_EN
    logic [CNT_W-1:0] w_loadClamped;

    // Out-of-range load values saturate at the top of the count range.
    assign w_loadClamped = (bus.load_value > CntMax) ? CntMax : bus.load_value;
`endif

    // Counter register: advances only on tick, wrap flags the cycle in which
    // the wrapped value appears on count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
`ifdef RTC_LOAD_EN
            if (bus.load) begin
                r_count <= w_loadClamped;
                r_wrap  <= 1'b0;
            end else
`endif
            if (w_tick) begin
                r_count <= w_countNext;
                r_wrap  <= w_atTerminal;
            end else begin
                r_wrap  <= 1'b0;
            end
        end
    end

    assign bus.tick  = w_tick;
    assign bus.count = r_count;
    assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_rate_tick_counter.sv
// ----------------------------------------------------------------------------
// tb_rate_tick_counter
//   Scoreboard bench for rate_tick_counter with small divisors and a
//   non-power-of-2 modulus. Stimulus pushes expected responses computed by a
//   behavioural model; a separate monitor pops and compares every cycle.
// ----------------------------------------------------------------------------
module tb_rate_tick_counter;

    localparam int DIV_W = 8;
    localparam int DIV1  = 4;
    localparam int DIV2  = 6;
    localparam int DIV3  = 9;
    localparam int CNT_W = 4;
    localparam int M     = 10;

    typedef struct {
        int tick;
        int count;
        int wrap;
    } expT;

    logic clock;
    logic reset;

    rate_tick_counter_if #(.CNT_W(CNT_W)) bus ();

    rate_tick_counter #(
        .DIV_W  (DIV_W),
        .DIV1   (DIV1),
        .DIV2   (DIV2),
        .DIV3   (DIV3),
        .CNT_W  (CNT_W),
        .MODULUS(M)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    expT expQ[$];
    int  compared   = 0;
    int  mismatched = 0;

    // Behavioural model: the tick schedule is a count of enabled cycles
    // since the last restart, ticking whenever it is a multiple of the period.
    int mSel     = 0;
    int mElapsed = 0;
    int mCount   = 0;

    // Clock generation: 10 time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic int divOf(input int sel);
        case (sel)
            1:       return DIV1;
            2:       return DIV2;
            3:       return DIV3;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs and pushes the expected tick (this cycle)
    // together with the count and wrap expected after the following edge.
    task automatic applyStimulus(input logic en, input logic [1:0] sel, input logic up,
                                 input logic ld, input logic [CNT_W-1:0] ldv);
        expT e;
        int  expTick;
        int  expWrap;
        @(posedge clock);
        #2;
        bus.enable   = en;
        bus.rate_sel = sel;
        bus.up_dn    = up;
`ifdef RTC_LOAD_EN
        bus.load       = ld;
        bus.load_value = ldv;
`endif
        expTick = 0;
        expWrap = 0;
        if (int'(sel) != mSel) begin
            mSel     = int'(sel);
            mElapsed = 1;
        end else if (en) begin
            expTick  = ((mElapsed % (divOf(mSel) + 1)) == 0) ? 1 : 0;
            mElapsed = mElapsed + 1;
        end
`ifdef RTC_LOAD_EN
        if (ld) begin
            mCount = (int'(ldv) > M - 1) ? M - 1 : int'(ldv);
        end else
`endif
        if (expTick == 1) begin
            if (up) begin
                expWrap = (mCount == M - 1) ? 1 : 0;
                mCount  = (mCount + 1) % M;
            end else begin
                expWrap = (mCount == 0) ? 1 : 0;
                mCount  = (mCount + M - 1) % M;
            end
        end
        e.tick  = expTick;
        e.count = mCount;
        e.wrap  = expWrap;
        expQ.push_back(e);
    endtask

    task automatic checkResetOutputs();
        checkOutput("reset_count", int'(bus.count), 0);
        checkOutput("reset_wrap",  int'(bus.wrap),  0);
        checkOutput("reset_tick",  int'(bus.tick),  0);
    endtask

    // Asserts reset with arbitrary inputs, checks the cleared outputs while
    // held, then parks the inputs in a no-op state before releasing.
    task automatic applyReset(input int cycles);
        @(posedge clock);
        #2;
        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.rate_sel = 2'($urandom_range(0, 3));
        bus.up_dn    = 1'($urandom_range(0, 1));
`ifdef RTC_LOAD_EN
        bus.load       = 1'($urandom_range(0, 1));
        bus.load_value = CNT_W'($urandom_range(0, 15));
`endif
        #1;
        checkResetOutputs();
        repeat (cycles) begin
            @(negedge clock);
            checkResetOutputs();
        end
        bus.enable   = 1'b0;
        bus.rate_sel = 2'b00;
`ifdef RTC_LOAD_EN
        bus.load     = 1'b0;
`endif
        @(posedge clock);
        #1;
        reset    = 1'b0;
        mSel     = 0;
        mElapsed = 0;
        mCount   = 0;
    endtask

    // Monitor: samples tick mid-cycle and count/wrap just after the edge.
    initial begin
        expT rec;
        int  obsTick;
        forever begin
            @(negedge clock);
            if (expQ.size() != 0) begin
                rec     = expQ.pop_front();
                obsTick = int'(bus.tick);
                @(posedge clock);
                #1;
                checkOutput("tick",  obsTick,         rec.tick);
                checkOutput("count", int'(bus.count), rec.count);
                checkOutput("wrap",  int'(bus.wrap),  rec.wrap);
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic       en;
        logic [1:0] sel;
        logic       up;
        logic       ld;
        logic [CNT_W-1:0] ldv;

        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.rate_sel = 2'b00;
        bus.up_dn    = 1'b1;
`ifdef RTC_LOAD_EN
        bus.load       = 1'b0;
        bus.load_value = '0;
`endif
        applyReset(3);

        $display("[TB] every-cycle tick, counting up through wrap");
        repeat (22) applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, '0);

        $display("[TB] DIV1 rate with enable freeze");
        applyReset(1);
        repeat (12) applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, '0);
        repeat (7)  applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, '0);
        repeat (8)  applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, '0);

        $display("[TB] counting down from zero");
        applyReset(1);
        repeat (12) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, '0);

        $display("[TB] rate change just before a tick");
        applyReset(1);
        repeat (4)  applyStimulus(1'b1, 2'b01, 1'b1, 1'b0, '0);
        repeat (10) applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, '0);
        repeat (3)  applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, '0);
        repeat (12) applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, '0);

`ifdef RTC_LOAD_EN
        $display("[TB] clamped load coincident with tick");
        applyReset(1);
        repeat (3) applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, CNT_W'(12));
        repeat (3) applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, CNT_W'(4));
        repeat (6) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, '0);
`endif

        $display("[TB] randomized traffic");
        sel = 2'b00;
        up  = 1'b1;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                applyReset(int'($urandom_range(1, 3)));
                sel = 2'b00;
            end
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 23) == 0) sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  up  = ~up;
            ld  = ($urandom_range(0, 19) == 0);
            ldv = CNT_W'($urandom_range(0, 15));
            applyStimulus(en, sel, up, ld, ldv);
        end

        for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
            @(posedge clock);
        end
        @(posedge clock);
        #3;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
